// File: rtl/rca_seq_pkg.sv
// Shared definitions for the multi-word ripple-carry sequencer: state encoding
// and the slice-counter width helper.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-slice build still needs a 1-bit counter.
  function automatic int cnt_width(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder; the shared slice datapath of the sequencer.
module ripple_carry_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_A,
  input  logic [N-1:0] i_B,
  input  logic         i_Cin,
  output logic [N-1:0] o_Sum,
  output logic         o_Cout
);

  // Kept as separate bits so the chain is a plain bit-to-bit ripple.
  logic carry [N+1];

  assign carry[0] = i_Cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign o_Sum[gi]     = i_A[gi] ^ i_B[gi] ^ carry[gi];
      assign carry[gi + 1] = (i_A[gi] & i_B[gi]) | (carry[gi] & (i_A[gi] ^ i_B[gi]));
    end
  endgenerate

  assign o_Cout = carry[N];

endmodule

// File: rtl/rca_multiword_sequencer.sv
// Multi-precision add/subtract controller: runs one N-bit ripple-carry adder
// over WORDS slices, LSB first, with the carry registered between slices.
module rca_multiword_sequencer
  import rca_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Start,
  input  logic               i_Sub,
  input  logic [N*WORDS-1:0] i_A,
  input  logic [N*WORDS-1:0] i_B,
  input  logic               i_Cin,
  output logic               o_Ready,
  output logic               o_Busy,
  output logic               o_Done,
  output logic [N*WORDS-1:0] o_Sum,
  output logic               o_Cout,
  output logic               o_Ovf
);

  localparam int W  = N * WORDS;
  localparam int CW = cnt_width(WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   idx_reg, idx_next;
  logic            carry_reg, carry_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic [N-1:0]    acc_reg [WORDS];
  logic [N-1:0]    acc_next [WORDS];
  logic [W-1:0]    sum_reg, sum_next;
  logic            cout_reg, cout_next;
  logic            ovf_reg, ovf_next;

  logic [N-1:0]    a_slice [WORDS];
  logic [N-1:0]    b_slice [WORDS];
  logic [N-1:0]    slice_sum;
  logic            slice_cout;
  logic [W-1:0]    acc_flat;

  // acc_flat already carries the slice being computed this cycle, so the
  // completion edge can publish the whole word at once.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
      assign a_slice[gi]           = a_reg[gi*N +: N];
      assign b_slice[gi]           = b_reg[gi*N +: N];
      assign acc_flat[gi*N +: N]   = (idx_reg == CW'(gi)) ? slice_sum : acc_reg[gi];
    end
  endgenerate

  ripple_carry_adder #(.N(N)) u_adder (
    .i_A    (a_slice[idx_reg]),
    .i_B    (b_slice[idx_reg]),
    .i_Cin  (carry_reg),
    .o_Sum  (slice_sum),
    .o_Cout (slice_cout)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    carry_next = carry_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (i_Start) begin
          state_next = RUN;
          idx_next   = '0;
          a_next     = i_A;
          b_next     = i_Sub ? ~i_B : i_B;
          carry_next = i_Sub ? 1'b1 : i_Cin;
        end
      end
      RUN: begin
        acc_next[idx_reg] = slice_sum;
        carry_next        = slice_cout;
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
          sum_next   = acc_flat;
          cout_next  = slice_cout;
          ovf_next   = (a_reg[W-1] == b_reg[W-1]) && (acc_flat[W-1] != a_reg[W-1]);
        end else begin
          idx_next = idx_reg + CW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      for (int i = 0; i < WORDS; i++) acc_reg[i] <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      carry_reg <= carry_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign o_Ready = (state_reg == IDLE);
  assign o_Busy  = (state_reg == RUN);
  assign o_Done  = (state_reg == DONE);
  assign o_Sum   = sum_reg;
  assign o_Cout  = cout_reg;
  assign o_Ovf   = ovf_reg;

endmodule

// File: tb/tb_rca_multiword_sequencer.sv
// Scoreboard bench for rca_multiword_sequencer (N=4, WORDS=4): directed cases,
// handshake and reset scenarios, then a randomized back-to-back regression.
module tb_rca_multiword_sequencer;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  rca_multiword_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .i_Start (start),
    .i_Sub   (sub),
    .i_A     (a),
    .i_B     (b),
    .i_Cin   (cin),
    .o_Ready (ready),
    .o_Busy  (busy),
    .o_Done  (done),
    .o_Sum   (sum),
    .o_Cout  (cout),
    .o_Ovf   (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           acc_count = 0;
  int           last_acc = 0;
  bit           have_acc = 1'b0;
  bit           b2b = 1'b0;
  int           op_no = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, overflow from signed range.
  function automatic exp_t ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                  input logic rcin, input logic rsub);
    exp_t        e;
    int          ua, ub, sa, sb_i, sr;
    int unsigned ur;
    ua   = int'(ra);
    ub   = int'(rb);
    sa   = int'($signed(ra));
    sb_i = int'($signed(rb));
    if (rsub) begin
      e.sum  = W'(ua - ub);
      e.cout = (ua >= ub);
      sr     = sa - sb_i;
    end else begin
      ur     = int'(ua + ub + int'(rcin));
      e.sum  = ur[W-1:0];
      e.cout = ur[W];
      sr     = sa + sb_i + int'(rcin);
    end
    e.ovf     = (sr > 32767) || (sr < -32768);
    e.acc_cyc = 0;
    return e;
  endfunction

  // Accept tracker: pushes the expected response when the DUT takes a request.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        sb.delete();
        have_acc  = 1'b0;
        last_sum  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
      end else if (start && ready) begin
        e = ref_op(a, b, cin, sub);
        e.acc_cyc = cyc + 1;
        if (b2b && have_acc) chk("b2b_spacing", 32'(cyc + 1 - last_acc), 32'd6);
        sb.push_back(e);
        last_acc = cyc + 1;
        have_acc = 1'b1;
        acc_count++;
      end
      cyc++;
    end
  end

  // Monitor: handshake phase, completion results and output stability.
  initial begin
    exp_t e;
    int   since;
    logic [2:0] exp_phase;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!have_acc) exp_phase = 3'b100;
        else begin
          since = cyc - last_acc;
          if (since < WORDS)       exp_phase = 3'b010;
          else if (since == WORDS) exp_phase = 3'b001;
          else                     exp_phase = 3'b100;
        end
        chk("ready_busy_done", {29'd0, ready, busy, done}, {29'd0, exp_phase});
        if (done) begin
          if (sb.size() == 0) begin
            chk("done_without_request", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("sum", 32'(sum), 32'(e.sum));
            chk("cout", 32'(cout), 32'(e.cout));
            chk("ovf", 32'(ovf), 32'(e.ovf));
            chk("latency", 32'(cyc - e.acc_cyc), 32'(WORDS));
            op_no++;
            $display("op %0d: sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     op_no, sum, cout, ovf, e.sum, e.cout, e.ovf);
          end
          last_sum  = sum;
          last_cout = cout;
          last_ovf  = ovf;
        end else begin
          chk("hold_sum", 32'(sum), 32'(last_sum));
          chk("hold_flags", {30'd0, cout, ovf}, {30'd0, last_cout, last_ovf});
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tcin, input logic tsub, input bit hold);
    int c0;
    a     = ta;
    b     = tb_v;
    cin   = tcin;
    sub   = tsub;
    start = 1'b1;
    c0    = acc_count;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (acc_count != c0) break;
    end
    if (acc_count == c0) chk("accept_timeout", 32'd0, 32'd1);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic tsub, input logic [W-1:0] xs,
                          input logic xc, input logic xo);
    issue(ta, tb_v, tcin, tsub, 1'b0);
    wait_idle();
    chk("dir_sum", 32'(sum), 32'(xs));
    chk("dir_flags", {30'd0, cout, ovf}, {30'd0, xc, xo});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {11'd0, ready, busy, done, cout, ovf, sum},
        {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outputs", {11'd0, ready, busy, done, cout, ovf, sum},
        {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});

    directed(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Start pulses during RUN and during DONE must be dropped.
    issue(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h5555; b = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("in_done_state", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("ignored_start_sum", 32'(sum), 32'h2222);

    // Reset after slice 2 of a rippling add.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_reset", {11'd0, ready, busy, done, cout, ovf, sum},
        {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    #2 rst_n = 1'b1;
    directed(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Random regression with Start held high between requests.
    for (int i = 0; i < 10000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1);
      b2b = 1'b1;
    end
    start = 1'b0;
    b2b   = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
